// File: rtl/mem_stage.sv
// MEM stage of the 5-stage in-order pipeline: completes data-SRAM accesses,
// holds an early response while WB stalls, aligns load data and forwards to ID.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_allow_in,
    input  logic        ex_to_mem_valid,
    input  logic [74:0] ex_to_mem_bus,
    input  logic        wb_allow_in,
    output logic        mem_to_wb_valid,
    output logic [69:0] mem_to_wb_bus,
    output logic [38:0] mem_to_id_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    logic        mem_valid_q, mem_valid_d;
    logic [74:0] mem_reg_q, mem_reg_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  load_op;

    logic        mem_ready_go;
    logic        leaving;
    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        fwd_we;
    logic        load_pending;

    assign {pc, alu_result, reg_we, reg_waddr, mem_req, res_from_mem, load_op} = mem_reg_q;

    // A buffered response counts as arrival, so a stalled instruction stays ready.
    assign mem_ready_go    = !mem_req || data_sram_data_ok || buf_valid_q;
    assign mem_allow_in    = !mem_valid_q || (mem_ready_go && wb_allow_in);
    assign mem_to_wb_valid = mem_valid_q && mem_ready_go;
    assign leaving         = mem_to_wb_valid && wb_allow_in;

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_reg_d   = mem_reg_q;
        if (mem_allow_in) begin
            mem_valid_d = ex_to_mem_valid;
            if (ex_to_mem_valid) begin
                mem_reg_d = ex_to_mem_bus;
            end
        end
    end

    // Clear on departure takes priority; fill only when data arrives but WB stalls.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (leaving) begin
            buf_valid_d = 1'b0;
        end else if (mem_valid_q && mem_req && !buf_valid_q
                     && data_sram_data_ok && !wb_allow_in) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            buf_valid_q <= buf_valid_d;
        end
        mem_reg_q  <= mem_reg_d;
        buf_data_q <= buf_data_d;
    end

    assign raw = buf_valid_q ? buf_data_q : data_sram_rdata;

    always_comb begin
        byte_sel = raw[7:0];
        case (alu_result[1:0])
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = alu_result[1] ? raw[31:16] : raw[15:0];

        load_data = raw;
        case (load_op)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b101:  load_data = {24'd0, byte_sel};
            3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b110:  load_data = {16'd0, half_sel};
            default: load_data = raw;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    assign fwd_we       = mem_valid_q && reg_we;
    assign load_pending = mem_valid_q && res_from_mem && !mem_ready_go;

    assign mem_to_wb_bus = {pc, final_result, reg_we, reg_waddr};
    assign mem_to_id_bus = {fwd_we, reg_waddr, final_result, load_pending};

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic, each
// cycle checked against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_allow_in;
    logic        ex_to_mem_valid;
    logic [74:0] ex_to_mem_bus;
    logic        wb_allow_in;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [38:0] mem_to_id_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .mem_allow_in      (mem_allow_in),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .wb_allow_in       (wb_allow_in),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_to_id_bus     (mem_to_id_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic        we;
        logic [4:0]  waddr;
        logic        req;
        logic        rfm;
        logic [2:0]  op;
    } instr_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: which instruction sits in MEM and whether its response is already held.
    bit          m_have_instr = 1'b0;
    instr_t      m_cur;
    bit          m_have_data  = 1'b0;
    logic [31:0] m_held;
    instr_t      stim;

    function automatic logic [74:0] to_bus(input instr_t i);
        return {i.pc, i.alu, i.we, i.waddr, i.req, i.rfm, i.op};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] raw);
        longint      v;
        int unsigned lane;
        case (op)
            3'b001, 3'b101: begin
                lane = addr % 4;
                v = (raw >> (8 * lane)) & 32'hff;
                if (op == 3'b001 && v >= 128) v = v - 256;
            end
            3'b010, 3'b110: begin
                lane = (addr / 2) % 2;
                v = (raw >> (16 * lane)) & 32'hffff;
                if (op == 3'b010 && v >= 32768) v = v - 65536;
            end
            default: v = raw;
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Check outputs against the model, clock once, then advance the model.
    task automatic step();
        bit          e_ready, e_allow, e_wbv, e_pend;
        logic [31:0] raw, e_final;
        #1;
        e_ready = m_have_instr && (!m_cur.req || data_sram_data_ok || m_have_data);
        e_allow = !m_have_instr || (e_ready && wb_allow_in);
        e_wbv   = m_have_instr && e_ready;
        e_pend  = m_have_instr && m_cur.rfm && !e_ready;
        chk("allow_in", mem_allow_in, e_allow);
        chk("wb_valid", mem_to_wb_valid, e_wbv);
        chk("fwd_we", mem_to_id_bus[38], m_have_instr && m_cur.we);
        chk("load_pending", mem_to_id_bus[0], e_pend);
        if (m_have_instr) begin
            raw     = m_have_data ? m_held : data_sram_rdata;
            e_final = m_cur.rfm ? model_load(m_cur.op, m_cur.alu, raw) : m_cur.alu;
            if (e_wbv)
                chk("wb_bus", mem_to_wb_bus, {m_cur.pc, e_final, m_cur.we, m_cur.waddr});
            if (!e_pend)
                chk("id_result", mem_to_id_bus[37:1], {m_cur.waddr, e_final});
        end
        @(posedge clk);
        if (reset) begin
            m_have_instr = 1'b0;
            m_have_data  = 1'b0;
        end else begin
            if (m_have_instr && m_cur.req && !m_have_data && data_sram_data_ok && !wb_allow_in) begin
                m_have_data = 1'b1;
                m_held      = data_sram_rdata;
            end
            if (e_wbv && wb_allow_in) m_have_data = 1'b0;
            if (e_allow) begin
                m_have_instr = ex_to_mem_valid;
                if (ex_to_mem_valid) m_cur = stim;
            end
        end
        @(negedge clk);
    endtask

    task automatic present(input instr_t i);
        stim            = i;
        ex_to_mem_bus   = to_bus(i);
        ex_to_mem_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; wb_allow_in = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        stim = '{32'h1c000000, 32'h12345678, 1'b1, 5'd5, 1'b0, 1'b0, 3'b000};
        present(stim);
        @(negedge clk);

        // Reset held two cycles with EX offering an instruction.
        repeat (2) begin
            #1;
            chk("rst_allow", mem_allow_in, 1'b1);
            chk("rst_wbv", mem_to_wb_valid, 1'b0);
            step();
        end
        reset = 1'b0;
        step();
        ex_to_mem_valid = 1'b0;
        #1;
        chk("alu_wbv", mem_to_wb_valid, 1'b1);
        chk("alu_bus", mem_to_wb_bus, {32'h1c000000, 32'h12345678, 1'b1, 5'd5});
        chk("alu_fwd", mem_to_id_bus[38], 1'b1);
        step();

        // ld.b / ld.bu at byte lane 2.
        for (int k = 0; k < 2; k++) begin
            present('{32'h1c000010, 32'h00001002, 1'b1, 5'd7, 1'b1, 1'b1, (k == 0) ? 3'b001 : 3'b101});
            step();
            ex_to_mem_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                chk("ldb_pending", mem_to_id_bus[0], 1'b1);
                chk("ldb_wait_wbv", mem_to_wb_valid, 1'b0);
                step();
            end
            data_sram_data_ok = 1'b1; data_sram_rdata = 32'h00AB0000;
            #1;
            chk("ldb_result", mem_to_wb_bus[37:6], (k == 0) ? 32'hFFFFFFAB : 32'h000000AB);
            step();
            data_sram_data_ok = 1'b0;
        end

        // ld.hu response arrives during a WB stall and must be buffered.
        present('{32'h1c000020, 32'h00002002, 1'b1, 5'd9, 1'b1, 1'b1, 3'b110});
        step();
        ex_to_mem_valid = 1'b0;
        wb_allow_in = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001FFFF;
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A5A5A;
        #1;
        chk("buf_hold_wbv", mem_to_wb_valid, 1'b1);
        chk("buf_hold_result", mem_to_wb_bus[37:6], 32'h00008001);
        step();
        wb_allow_in = 1'b1;
        #1;
        chk("buf_release", mem_to_wb_bus[37:6], 32'h00008001);
        step();
        present('{32'h1c000030, 32'h00003000, 1'b1, 5'd3, 1'b1, 1'b1, 3'b000});
        step();
        ex_to_mem_valid = 1'b0;
        #1;
        chk("buf_cleared", mem_to_id_bus[0], 1'b1);
        step();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        step();
        data_sram_data_ok = 1'b0;

        // Store followed back-to-back by an ALU op.
        present('{32'h1c000040, 32'h00004004, 1'b0, 5'd0, 1'b1, 1'b0, 3'b000});
        step();
        present('{32'h1c000044, 32'h0000BEEF, 1'b1, 5'd11, 1'b0, 1'b0, 3'b000});
        #1;
        chk("st_block", mem_allow_in, 1'b0);
        step();
        data_sram_data_ok = 1'b1;
        #1;
        chk("st_accept", mem_allow_in, 1'b1);
        chk("st_result", mem_to_wb_bus[69:6], {32'h1c000040, 32'h00004004});
        step();
        ex_to_mem_valid = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        chk("st_next_pc", mem_to_wb_bus[69:38], 32'h1c000044);
        step();

        // Reset while a load waits; the late response must be ignored.
        present('{32'h1c000050, 32'h00005000, 1'b1, 5'd12, 1'b1, 1'b1, 3'b000});
        step();
        ex_to_mem_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11112222;
        #1;
        chk("stray_wbv", mem_to_wb_valid, 1'b0);
        chk("stray_pending", mem_to_id_bus[0], 1'b0);
        step();
        data_sram_data_ok = 1'b0;
        #1;
        chk("stray_after", mem_to_wb_valid, 1'b0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            int unsigned kind;
            instr_t i;
            kind    = $urandom_range(0, 2);
            i.pc    = $urandom;
            i.alu   = $urandom;
            i.waddr = 5'($urandom);
            i.op    = 3'($urandom);
            i.req   = (kind != 0);
            i.rfm   = (kind == 1);
            i.we    = (kind == 2) ? 1'b0 : 1'($urandom);
            stim = i;
            ex_to_mem_bus     = to_bus(i);
            ex_to_mem_valid   = ($urandom_range(0, 99) < 60);
            wb_allow_in       = ($urandom_range(0, 99) < 70);
            data_sram_data_ok = ($urandom_range(0, 99) < 40);
            data_sram_rdata   = $urandom;
            reset             = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
